// File: rtl/aes_key_expansion_pkg.sv
// Shared widths and the controller state type for the AES-128 key expansion block.
package aes_key_expansion_pkg;

    localparam int BYTE_WIDTH      = 8;
    localparam int FOUR_BYTE_WIDTH = 32;
    localparam int KEY_WIDTH       = 128;
    localparam int NUM_ROUND_KEYS  = 11;
    localparam int ROUND_IDX_WIDTH = 4;

    // Index value one past the last valid round key; reads at or above it return zero.
    localparam logic [ROUND_IDX_WIDTH-1:0] NUM_KEYS_IDX = ROUND_IDX_WIDTH'(NUM_ROUND_KEYS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CALC = 2'd2
    } kx_state_t;

endpackage

// File: rtl/aes_key_expansion_if.sv
// Control and round-key read bus of the key expansion block.
interface aes_key_expansion_if;
    import aes_key_expansion_pkg::*;

    logic                       start_i;
    logic [KEY_WIDTH-1:0]       key_i;
    logic                       busy_o;
    logic                       done_o;
    logic                       key_valid_o;
    logic [ROUND_IDX_WIDTH-1:0] rd_idx_i;
    logic [KEY_WIDTH-1:0]       rd_key_o;

    // Requester side (cipher control / decryption datapath).
    modport master (
        output start_i, key_i, rd_idx_i,
        input  busy_o, done_o, key_valid_o, rd_key_o
    );

    // Key expansion block side.
    modport slave (
        input  start_i, key_i, rd_idx_i,
        output busy_o, done_o, key_valid_o, rd_key_o
    );
endinterface

// File: rtl/aes_key_expansion_round_key_store.sv
// 11 x 128-bit round key register file: one synchronous write port and one
// registered read port that returns zero for indices past the last key.
module round_key_store
    import aes_key_expansion_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [ROUND_IDX_WIDTH-1:0] i_wr_idx,
    input  logic [KEY_WIDTH-1:0]       i_wr_data,
    input  logic [ROUND_IDX_WIDTH-1:0] i_rd_idx,
    output logic [KEY_WIDTH-1:0]       o_rd_key
);

    logic [KEY_WIDTH-1:0] r_mem [NUM_ROUND_KEYS];
    logic [KEY_WIDTH-1:0] r_rd_key;

    // Key storage: contents are not reset, key_valid_o qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (i_wr_idx < NUM_KEYS_IDX)) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Registered read; the old contents are seen when reading the slot being written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_key <= {KEY_WIDTH{1'b0}};
        end else if (i_rd_idx < NUM_KEYS_IDX) begin
            r_rd_key <= r_mem[i_rd_idx];
        end else begin
            r_rd_key <= {KEY_WIDTH{1'b0}};
        end
    end

    assign o_rd_key = r_rd_key;

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key expansion controller feeding an external S-box ROM.
// One round key is produced per SBOX_LATENCY cycles; all 11 keys are kept in
// a random-access store for the decryption datapath.
module aes_key_expansion
    import aes_key_expansion_pkg::*;
#(
    parameter int SBOX_LATENCY = 1,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    aes_key_expansion_if.slave         bus,
    output logic [FOUR_BYTE_WIDTH-1:0] sbox_word_o,
    input  logic [FOUR_BYTE_WIDTH-1:0] sbox_word_i
);

    localparam logic [1:0]                 WAIT_RELOAD = 2'(SBOX_LATENCY - 1);
    localparam kx_state_t                  ROUND_STATE = (SBOX_LATENCY > 1) ? ST_WAIT : ST_CALC;
    localparam logic [ROUND_IDX_WIDTH-1:0] LAST_ROUND  = ROUND_IDX_WIDTH'(NUM_ROUNDS);

    // AES round constant byte for rounds 1..10.
    function automatic logic [BYTE_WIDTH-1:0] rcon(input logic [ROUND_IDX_WIDTH-1:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    kx_state_t                  r_state,  w_state_nxt;
    logic [ROUND_IDX_WIDTH-1:0] r_round,  w_round_nxt;
    logic [1:0]                 r_wait,   w_wait_nxt;
    logic [KEY_WIDTH-1:0]       r_work,   w_work_nxt;
    logic                       r_busy,   w_busy_nxt;
    logic                       r_done,   w_done_nxt;
    logic                       r_valid,  w_valid_nxt;

    logic                       w_wr_en;
    logic [ROUND_IDX_WIDTH-1:0] w_wr_idx;
    logic [KEY_WIDTH-1:0]       w_wr_data;
    logic [FOUR_BYTE_WIDTH-1:0] w_t;
    logic [FOUR_BYTE_WIDTH-1:0] w_n0, w_n1, w_n2, w_n3;
    logic [KEY_WIDTH-1:0]       w_next_key;

    // Next round key from the S-box result and the current working key.
    always_comb begin
        w_t        = sbox_word_i ^ {rcon(r_round), 24'h000000};
        w_n0       = r_work[127:96] ^ w_t;
        w_n1       = r_work[95:64]  ^ w_n0;
        w_n2       = r_work[63:32]  ^ w_n1;
        w_n3       = r_work[31:0]   ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
    end

    // Next-state, counters, status flags and store write control.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_wait_nxt  = r_wait;
        w_work_nxt  = r_work;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_valid_nxt = r_valid;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_round;
        w_wr_data   = w_next_key;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_work_nxt  = bus.key_i;
                    w_wr_en     = 1'b1;
                    w_wr_idx    = 4'd0;
                    w_wr_data   = bus.key_i;
                    w_round_nxt = 4'd1;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_wait_nxt  = WAIT_RELOAD;
                    w_state_nxt = ROUND_STATE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_wait_nxt = r_wait - 2'd1;
                if (r_wait <= 2'd1) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_CALC: begin
                w_wr_en    = 1'b1;
                w_work_nxt = w_next_key;
                if (r_round == LAST_ROUND) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                    w_wait_nxt  = WAIT_RELOAD;
                    w_state_nxt = ROUND_STATE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Controller state and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
            r_wait  <= 2'd0;
            r_work  <= {KEY_WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_wait  <= w_wait_nxt;
            r_work  <= w_work_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // A reset edge must not commit a pending round key.
    round_key_store u_store (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_wr_en   (w_wr_en & ~rst_i),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (bus.rd_idx_i),
        .o_rd_key  (bus.rd_key_o)
    );

    // RotWord of w3 straight from the working register, stable between rounds.
    assign sbox_word_o     = {r_work[23:0], r_work[31:24]};
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.key_valid_o = r_valid;

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key-expansion controller that sits directly upstream of S_box_memory.
- Drives RotWord(w3) into the S-box ROM, consumes SubWord from it, XORs with Rcon, and produces round keys 1..10.
- All 11 round keys (0..10) are held in an internal key store with a random-access read port, so the decryption datapath can fetch keys in reverse order (10 down to 0).

Parameters:
- SBOX_LATENCY, 1, posedges from a stable sbox_word_o to a valid sbox_word_i. Legal range 1..3. S_box_memory registers on negedge, which gives 1.
- NUM_ROUNDS, 10, number of expansion rounds. Fixed for AES-128; the parameter exists for readability only.

Ports:
- clk_i  in  1  single clock, rising-edge logic.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to expand key_i. Ignored while busy_o=1.
- key_i  in  128  cipher key, {w0,w1,w2,w3}, w0 = [127:96]. Sampled only on an accepted start.
- busy_o  out  1  high while rounds 1..10 are being computed.
- done_o  out  1  one-cycle pulse when round key 10 is written.
- key_valid_o  out  1  level; all 11 keys are valid.
- sbox_word_o  out  32  to S_box_memory W_i; equals RotWord(current w3) = {w3[23:0], w3[31:24]}.
- sbox_word_i  in  32  from S_box_memory W_o.
- rd_idx_i  in  4  round-key index to read.
- rd_key_o  out  128  registered round key at rd_idx_i.

Behaviour:
- Reset (synchronous, rst_i=1 at a posedge):
  - busy_o=0, done_o=0, key_valid_o=0, rd_key_o=0.
  - Working key register = 0, so sbox_word_o=0.
  - Round counter = 0, FSM = IDLE.
  - Key store contents are don't-care; key_valid_o gates their use.
  - Reset mid-expansion aborts immediately. No further store writes occur.
- FSM states: IDLE, WAIT, CALC.
- IDLE, start_i=1 at edge S:
  - Load key_i into the working register and write it to store[0].
  - Round counter = 1, key_valid_o -> 0, busy_o -> 1.
  - Wait counter = SBOX_LATENCY-1. Go to WAIT if SBOX_LATENCY>1, else CALC.
- WAIT: decrement the wait counter each edge; go to CALC when it reaches 0.
  - sbox_word_o must stay stable throughout; it changes only when the working register changes.
- CALC (one edge), with t = sbox_word_i ^ {Rcon[round], 24'h0}:
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Write {w0',w1',w2',w3'} to the working register and to store[round].
  - If round < 10: increment round, reload the wait counter, go to WAIT (or stay in CALC if SBOX_LATENCY=1).
  - If round = 10: busy_o -> 0, done_o -> 1 for one cycle, key_valid_o -> 1, go to IDLE.
- Timing: round key r is written at edge S + r·SBOX_LATENCY. With the default, the last write and done_o both occur at S+10.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- start_i while busy_o=1 is ignored, with no side effects.
- start_i on the same cycle as the done_o pulse is accepted, since the FSM is then in IDLE.
- Read port:
  - rd_key_o <= store[rd_idx_i] on every edge (1-cycle latency), independent of the FSM.
  - rd_idx_i in 11..15 returns 128'h0.
  - A read during expansion returns stored contents, which may be stale; consumers must wait for key_valid_o.
  - A read of the index being written on the same edge returns the old value (read-before-write).

Decomposition:
- The shared defines file already holds BYTE_WIDTH (8) and FOUR_BYTE_WIDTH (32). Add KEY_WIDTH (128), NUM_ROUND_KEYS (11) and ROUND_IDX_WIDTH (4) there.
- The Rcon values live as a case-based function inside the block.
- One natural sub-module: round_key_store, an 11×128 register file with one synchronous write port and one registered read port that returns zero when out of range.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, with the real S_box_memory attached:
  - done_o high at exactly S+10.
  - store[1] = a0fafe1788542cb123a339392a6c7605.
  - store[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - store[0] = key_i.
- After done_o, read indices 10 down to 0 on consecutive cycles: each rd_key_o matches the FIPS value one cycle after its index. Index 12 returns 0.
- Pulse start_i at S+3 during the expansion: ignored, and round keys are identical to the previous test.
- Assert rst_i at S+5: the next edge gives busy_o=0, key_valid_o=0, sbox_word_o=0. A fresh start then completes normally.
- Behavioural S-box model with SBOX_LATENCY=3 and a key of all zeros:
  - done_o at S+30.
  - store[1] = 62636363626363636263636362636363.
  - sbox_word_o constant across each 3-cycle window.
- Back-to-back: start asserted in the done_o cycle with a new key is accepted, key_valid_o drops the next cycle, and the new keys are correct.
